// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state codes and watchdog default for the multicycle controller
package cpu_ctrl_pkg;

    localparam int DEFAULT_TIMEOUT = 255;

    // Codes 6 and 7 are never produced; the controller maps them back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EXE  = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5
    } state_t;

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - saturating per-stage dwell counter with expiry flag
//
// Ports:
//   clk     - clock, rising edge
//   resetn  - synchronous active-low reset, counter to 0
//   clear   - restart the count from 0 (asserted on every state change)
//   enable  - advance the count by one, saturating at TIMEOUT
//   expired - high while the count equals TIMEOUT
module stage_watchdog
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - IF/ID/EXE/MEM/WB sequencing FSM with halt, retire count and watchdog
//
// Ports:
//   clk, resetn                         - clock and synchronous active-low reset
//   run                                 - level enable to start/continue execution
//   halt_req                            - pulse: stop after the current instruction
//   IF_over..WB_over                    - stage-complete pulses, honoured only in their own stage
//   need_mem                            - decode result, sampled with an accepted ID_over
//   IF_valid..WB_valid                  - one-hot stage enables (Moore)
//   next_fetch                          - PC-advance strobe, coincident with retirement
//   state                               - current state code
//   inst_count                          - retired instruction count (wraps)
//   busy                                - state is not IDLE
//   timeout_err                         - sticky watchdog abort flag
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        halt_req,
    input  logic        IF_over,
    input  logic        ID_over,
    input  logic        EXE_over,
    input  logic        MEM_over,
    input  logic        WB_over,
    input  logic        need_mem,
    output logic        IF_valid,
    output logic        ID_valid,
    output logic        EXE_valid,
    output logic        MEM_valid,
    output logic        WB_valid,
    output logic        next_fetch,
    output logic [2:0]  state,
    output logic [31:0] inst_count,
    output logic        busy,
    output logic        timeout_err
);

    state_t      state_q, state_d;
    logic        mem_flag_q, mem_flag_d;
    logic        halt_pending_q, halt_pending_d;
    logic        timeout_err_q;
    logic [31:0] inst_count_q;
    logic        accepted;
    logic        retire;
    logic        wd_abort;
    logic        wd_expired;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            mem_flag_q     <= 1'b0;
            halt_pending_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            inst_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            mem_flag_q     <= mem_flag_d;
            halt_pending_q <= halt_pending_d;
            if (wd_abort) begin
                timeout_err_q <= 1'b1;
            end
            if (retire) begin
                inst_count_q <= inst_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_flag_d = mem_flag_q;
        accepted   = 1'b0;
        retire     = 1'b0;
        wd_abort   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run && !timeout_err_q) begin
                    state_d = ST_IF;
                end
            end
            ST_IF: begin
                if (IF_over) begin
                    accepted = 1'b1;
                    state_d  = ST_ID;
                end
            end
            ST_ID: begin
                if (ID_over) begin
                    accepted   = 1'b1;
                    mem_flag_d = need_mem;
                    state_d    = ST_EXE;
                end
            end
            ST_EXE: begin
                if (EXE_over) begin
                    accepted = 1'b1;
                    state_d  = mem_flag_q ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                if (MEM_over) begin
                    accepted = 1'b1;
                    state_d  = ST_WB;
                end
            end
            ST_WB: begin
                if (WB_over) begin
                    accepted = 1'b1;
                    retire   = 1'b1;
                    // A halt arriving in the retirement cycle itself still counts.
                    state_d  = (halt_pending_q || halt_req || !run) ? ST_IDLE : ST_IF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion wins over expiry in the same cycle.
        if (state_q inside {ST_IF, ST_ID, ST_EXE, ST_MEM, ST_WB} && !accepted && wd_expired) begin
            wd_abort = 1'b1;
            state_d  = ST_IDLE;
        end
    end

    always_comb begin
        halt_pending_d = halt_pending_q;
        if (state_q != ST_IDLE && halt_req) begin
            halt_pending_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            halt_pending_d = 1'b0;
        end
    end

    stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state_d != state_q),
        .enable  (1'b1),
        .expired (wd_expired)
    );

    assign IF_valid    = (state_q == ST_IF);
    assign ID_valid    = (state_q == ST_ID);
    assign EXE_valid   = (state_q == ST_EXE);
    assign MEM_valid   = (state_q == ST_MEM);
    assign WB_valid    = (state_q == ST_WB);
    assign busy        = (state_q != ST_IDLE);
    assign state       = state_q;
    assign inst_count  = inst_count_q;
    assign timeout_err = timeout_err_q;
    // Gated by resetn so a WB_over during reset cannot advance the PC.
    assign next_fetch  = resetn && retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TO     = 255;
    localparam int S_IDLE = 0;
    localparam int S_IF   = 1;
    localparam int S_ID   = 2;
    localparam int S_EXE  = 3;
    localparam int S_MEM  = 4;
    localparam int S_WB   = 5;

    logic        clk = 1'b0;
    logic        resetn, run, halt_req, need_mem;
    logic        IF_over, ID_over, EXE_over, MEM_over, WB_over;
    logic        IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
    logic        next_fetch, busy, timeout_err;
    logic [2:0]  state;
    logic [31:0] inst_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = '0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .run(run), .halt_req(halt_req),
        .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
        .MEM_over(MEM_over), .WB_over(WB_over), .need_mem(need_mem),
        .IF_valid(IF_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
        .MEM_valid(MEM_valid), .WB_valid(WB_valid), .next_fetch(next_fetch),
        .state(state), .inst_count(inst_count), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [4:0] valids();
        return {WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid};
    endfunction

    task automatic clear_pulses();
        IF_over = 0; ID_over = 0; EXE_over = 0; MEM_over = 0; WB_over = 0;
        need_mem = 0; halt_req = 0;
    endtask

    task automatic set_over(input int s, input logic v);
        case (s)
            S_IF:    IF_over  = v;
            S_ID:    ID_over  = v;
            S_EXE:   EXE_over = v;
            S_MEM:   MEM_over = v;
            default: WB_over  = v;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_pulses();
        resetn = 0;
        run    = 0;
        repeat (2) @(negedge clk);
        resetn    = 1;
        exp_count = '0;
    endtask

    // One instruction starting in IF; each stage's over comes d cycles after its valid.
    task automatic exec_inst(input bit mem, input int d, input int halt_at,
                             input bit noise, input bit run_after, input int reset_at);
        int          seq[$];
        logic [4:0]  exp_v;
        logic [31:0] r;
        seq = '{S_IF, S_ID, S_EXE};
        if (mem) seq.push_back(S_MEM);
        seq.push_back(S_WB);
        foreach (seq[k]) begin
            for (int c = 0; c <= d; c++) begin
                @(negedge clk);
                clear_pulses();
                exp_v = 5'b00001 << (seq[k] - 1);
                checks++;
                if (state !== 3'(seq[k]) || valids() !== exp_v || busy !== 1'b1 || inst_count !== exp_count) begin
                    errors++;
                    $display("FAIL stage_walk: state=%0d valids=%b busy=%b count=%0d, expected state=%0d valids=%b busy=1 count=%0d",
                             state, valids(), busy, inst_count, seq[k], exp_v, exp_count);
                end
                if (reset_at == seq[k]) begin
                    resetn = 0;
                    if (seq[k] == S_WB) WB_over = 1;
                    #1;
                    checks++;
                    if (next_fetch !== 1'b0) begin
                        errors++;
                        $display("FAIL fetch_in_reset: next_fetch=%b expected 0", next_fetch);
                    end
                    exp_count = '0;
                    return;
                end
                if (halt_at == seq[k] && c == 0) halt_req = 1;
                if (c == d) begin
                    set_over(seq[k], 1'b1);
                    if (seq[k] == S_ID) need_mem = mem;
                    if (seq[k] == S_WB) run = run_after;
                end else if (noise) begin
                    r = $urandom;
                    for (int j = S_IF; j <= S_WB; j++) begin
                        if (j != seq[k]) set_over(j, r[j]);
                    end
                    need_mem = r[8];
                end
                #1;
                checks++;
                if (next_fetch !== (seq[k] == S_WB && c == d)) begin
                    errors++;
                    $display("FAIL next_fetch: stage=%0d cycle=%0d got=%b expected=%b",
                             seq[k], c, next_fetch, (seq[k] == S_WB && c == d));
                end
            end
        end
        exp_count = exp_count + 32'd1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_pulses();
        resetn = 0; run = 0; WB_over = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 3'd0 || valids() !== 5'b0 || busy !== 0 || inst_count !== 32'd0 ||
            timeout_err !== 0 || next_fetch !== 0) begin
            errors++;
            $display("FAIL reset_state: state=%0d valids=%b busy=%b count=%0d terr=%b nf=%b expected all 0",
                     state, valids(), busy, inst_count, timeout_err, next_fetch);
        end
        WB_over = 0;
        resetn  = 1;
        exp_count = '0;
    endtask

    task automatic test_basic();
        do_reset();
        run = 1;
        exec_inst(0, 2, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (state !== 3'(S_IF) || inst_count !== 32'd1) begin
            errors++;
            $display("FAIL basic_back_to_if: state=%0d count=%0d expected state=1 count=1", state, inst_count);
        end
    endtask

    task automatic test_mem();
        do_reset();
        run = 1;
        exec_inst(1, 2, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (state !== 3'(S_IF) || inst_count !== 32'd1) begin
            errors++;
            $display("FAIL mem_path: state=%0d count=%0d expected state=1 count=1", state, inst_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1;
        exec_inst(0, 2, S_EXE, 0, 1, 0);
        @(negedge clk);
        clear_pulses();
        checks++;
        if (state !== 3'(S_IDLE) || busy !== 0 || inst_count !== 32'd1) begin
            errors++;
            $display("FAIL halt_stop: state=%0d busy=%b count=%0d expected state=0 busy=0 count=1",
                     state, busy, inst_count);
        end
        // halt_req in IDLE must not leave a pending halt behind
        run = 0; halt_req = 1;
        @(negedge clk);
        clear_pulses();
        checks++;
        if (state !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL halt_idle_hold: state=%0d expected 0", state);
        end
        run = 1;
        exec_inst(0, 1, 0, 0, 1, 0);
        @(negedge clk);
        clear_pulses();
        checks++;
        if (state !== 3'(S_IF) || inst_count !== 32'd2) begin
            errors++;
            $display("FAIL halt_idle_ignored: state=%0d count=%0d expected state=1 count=2", state, inst_count);
        end
        // halt coincident with WB_over
        exec_inst(0, 0, S_WB, 0, 1, 0);
        @(negedge clk);
        clear_pulses();
        checks++;
        if (state !== 3'(S_IDLE) || inst_count !== 32'd3) begin
            errors++;
            $display("FAIL halt_coincident: state=%0d count=%0d expected state=0 count=3", state, inst_count);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        run = 1;
        @(negedge clk);
        clear_pulses();
        EXE_over = 1;
        bad = (state !== 3'(S_IF)) ? 1 : 0;
        for (int i = 1; i < TO + 1; i++) begin
            @(negedge clk);
            clear_pulses();
            if (state !== 3'(S_IF)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_dwell: %0d cycles out of IF, expected 0", bad);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 3'(S_IDLE) || timeout_err !== 1 || next_fetch !== 0 || inst_count !== 32'd0) begin
            errors++;
            $display("FAIL timeout_abort: state=%0d terr=%b nf=%b count=%0d expected state=0 terr=1 nf=0 count=0",
                     state, timeout_err, next_fetch, inst_count);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (state !== 3'(S_IDLE) || timeout_err !== 1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_sticky: %0d cycles restarted, expected 0", bad);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (timeout_err !== 0) begin
            errors++;
            $display("FAIL timeout_clear: terr=%b expected 0", timeout_err);
        end
    endtask

    task automatic test_over_beats_expiry();
        do_reset();
        run = 1;
        repeat (TO) @(negedge clk);
        @(negedge clk);
        IF_over = 1;
        @(negedge clk);
        clear_pulses();
        checks++;
        if (state !== 3'(S_ID) || timeout_err !== 0) begin
            errors++;
            $display("FAIL over_priority: state=%0d terr=%b expected state=2 terr=0", state, timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1;
        for (int i = 0; i < 5; i++) exec_inst(1'($urandom), 1, 0, 0, 1, 0);
        exec_inst(1, 1, 0, 0, 1, S_MEM);
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || inst_count !== 32'd0 || valids() !== 5'b0) begin
            errors++;
            $display("FAIL reset_in_mem: state=%0d count=%0d valids=%b expected 0 0 00000",
                     state, inst_count, valids());
        end
        clear_pulses();
        resetn = 1;
        exec_inst(0, 1, 0, 0, 1, S_WB);
        @(negedge clk);
        clear_pulses();
        checks++;
        if (state !== 3'd0 || inst_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_wb: state=%0d count=%0d expected 0 0", state, inst_count);
        end
        resetn = 1;
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut.inst_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.inst_count_q;
        exp_count = 32'hFFFF_FFFF;
        run = 1;
        exec_inst(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (inst_count !== 32'd0 || state !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL count_wrap: count=%0h state=%0d expected count=0 state=0", inst_count, state);
        end
    endtask

    task automatic test_random();
        bit mem, run_after, halted;
        int d, halt_at;
        do_reset();
        run = 1;
        for (int n = 0; n < 30; n++) begin
            mem       = 1'($urandom);
            d         = int'($urandom_range(0, 3));
            halt_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_after = ($urandom_range(0, 3) != 0);
            halted    = (halt_at != 0) && (halt_at != S_MEM || mem);
            exec_inst(mem, d, halt_at, 1, run_after, 0);
            if (halted || !run_after) begin
                @(negedge clk);
                clear_pulses();
                checks++;
                if (state !== 3'(S_IDLE) || busy !== 0) begin
                    errors++;
                    $display("FAIL random_stop: state=%0d busy=%b expected state=0 busy=0", state, busy);
                end
                run = 1;
            end
        end
        @(negedge clk);
        checks++;
        if (inst_count !== exp_count) begin
            errors++;
            $display("FAIL random_count: count=%0d expected %0d", inst_count, exp_count);
        end
    endtask

    initial begin
        clear_pulses();
        resetn = 0;
        run    = 0;
        test_reset();
        test_basic();
        test_mem();
        test_halt();
        test_timeout();
        test_over_beats_expiry();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles any stage may stay active before a watchdog abort.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port run  input  1  level enable for starting and continuing instruction execution.
REQ-005 SHALL have port halt_req  input  1  single-cycle request to stop after the current instruction.
REQ-006 SHALL have ports IF_over, ID_over, EXE_over, MEM_over, WB_over  input  1 each  stage-complete pulses.
REQ-007 SHALL have port need_mem  input  1  decode result, meaningful only in the cycle ID_over=1.
REQ-008 SHALL have ports IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid  output  1 each  active-high stage enables.
REQ-009 SHALL have port next_fetch  output  1  PC-advance strobe to the fetch stage.
REQ-010 SHALL have port state  output  3  current FSM state code.
REQ-011 SHALL have port inst_count  output  32  number of retired instructions.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port timeout_err  output  1  sticky watchdog-abort flag.

Function
REQ-014 SHALL implement states IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-015 SHALL move IDLE->IF on the first cycle with run=1 and timeout_err=0.
REQ-016 SHALL move IF->ID on IF_over, and ID->EXE on ID_over while registering need_mem into an internal mem_flag.
REQ-017 SHALL move EXE->MEM on EXE_over when mem_flag=1, and EXE->WB on EXE_over when mem_flag=0.
REQ-018 SHALL move MEM->WB on MEM_over.
REQ-019 SHALL, on WB_over, move to IDLE if halt_pending=1 or run=0, and to IF otherwise.
REQ-020 SHALL ignore any *_over pulse that does not belong to the current state.
REQ-021 SHALL decode each *_valid as a Moore output, high exactly while state equals its stage, with exactly one valid high outside IDLE.
REQ-022 SHALL drive next_fetch combinationally as (state==WB && WB_over), a one-cycle strobe coincident with retirement, so the PC updates on the same edge as WB->X.
REQ-023 SHALL increment inst_count by 1 on every WB_over accepted in WB, wrapping 0xFFFFFFFF->0.
REQ-024 SHALL set halt_pending on halt_req whenever state is not IDLE, SHALL clear it when IDLE is entered, and SHALL ignore halt_req while in IDLE.
REQ-025 SHALL honour halt when halt_req and WB_over coincide: retire the instruction, pulse next_fetch, go IDLE.
REQ-026 SHALL reset the watchdog counter to 0 on every state change and increment it, saturating, each cycle the state is unchanged.
REQ-027 SHALL, when the watchdog reaches TIMEOUT in a non-IDLE state, go IDLE, set timeout_err, and leave next_fetch low and inst_count unchanged.
REQ-028 SHALL give an accepted *_over priority over a watchdog expiry in the same cycle.
REQ-029 SHALL stay in IDLE while timeout_err=1, which only resetn clears.

Reset
REQ-030 SHALL, with resetn=0 at a clock edge in any state, set state=IDLE, all valids=0, inst_count=0, watchdog=0, mem_flag=0, halt_pending=0 and timeout_err=0.
REQ-031 SHALL hold next_fetch=0 during reset, regardless of WB_over.

Structure
REQ-032 SHALL place the state codes (3-bit) and the TIMEOUT default in a shared package cpu_ctrl_pkg.
REQ-033 SHALL implement the watchdog as sub-module stage_watchdog, with inputs clk, resetn, clear and enable and output expired.

Verification
REQ-034 SHALL test: run=1, each *_over 2 cycles after its valid, need_mem=0 -> sequence IF,ID,EXE,WB, one next_fetch, inst_count=1, back to IF.
REQ-035 SHALL test: need_mem=1 at ID_over -> MEM_valid asserted after EXE_over, WB follows MEM_over, inst_count=1.
REQ-036 SHALL test: halt_req pulsed during EXE, then WB_over -> next_fetch=1 that cycle, state=IDLE, busy=0, inst_count=1.
REQ-037 SHALL test: EXE_over pulsed in IF, then no IF_over for 255 cycles -> still IF until expiry, then IDLE, timeout_err=1, run=1 cannot restart.
REQ-038 SHALL test: resetn=0 asserted in MEM with inst_count=5 -> next cycle state=0, inst_count=0, all valids 0.
REQ-039 SHALL test: inst_count forced to 0xFFFFFFFF, then one retirement -> inst_count=0.
